// File: rtl/cla_nibble_seq_adder_if.sv
// Request/result bundle between a requester and the nibble-serial CLA adder.
// The sub field exists only when CLA_SEQ_SUB_EN is defined.
interface cla_nibble_seq_adder_if #(parameter int WIDTH = 16);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef CLA_SEQ_SUB_EN
  logic             sub;
`endif
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  // Handshake: a request is taken on a rising edge where start=1 and ready=1;
  // done is high for one cycle when sum/cout/ovf are valid, and the result is
  // held until the next accepted request. start while ready=0 is dropped.
`ifdef CLA_SEQ_SUB_EN
  modport master (output start, a, b, cin, sub,
                  input  ready, busy, done, sum, cout, ovf);
  modport slave  (input  start, a, b, cin, sub,
                  output ready, busy, done, sum, cout, ovf);
`else
  modport master (output start, a, b, cin,
                  input  ready, busy, done, sum, cout, ovf);
  modport slave  (input  start, a, b, cin,
                  output ready, busy, done, sum, cout, ovf);
`endif
endinterface

// File: rtl/cla_nibble_seq_adder.sv
// Multi-cycle WIDTH-bit adder: one shared 4-bit carry-lookahead slice, one nibble
// per clock, LSB first. Optional subtract mode under macro CLA_SEQ_SUB_EN.
module cla_nibble_seq_adder #(
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  cla_nibble_seq_adder_if.slave    bus,
  output logic [1:0]               dbg_state
);
  localparam int NIB = WIDTH / 4;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIB - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t           state_q, state_d;
  logic             accept;
  logic [IW-1:0]    idx_q;
  logic             carry_q;
  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic             cout_q, ovf_q;
  logic             sub_in;

  logic [3:0] an, bn, g, p, c, snib;

`ifdef CLA_SEQ_SUB_EN
  assign sub_in = bus.sub;
`else
  assign sub_in = 1'b0;
`endif

  // Shared 4-bit lookahead slice working on the currently selected nibble.
  always_comb begin
    an = a_q[{idx_q, 2'b00} +: 4];
    bn = b_q[{idx_q, 2'b00} +: 4];
    g  = an & bn;
    p  = an ^ bn;
    c[0] = g[0] | (p[0] & carry_q);
    c[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & carry_q);
    c[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & carry_q);
    c[3] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & carry_q);
    snib = p ^ {c[2:0], carry_q};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (idx_q == LAST) state_d = DONE;
      end
      DONE: begin
        // A request held through DONE is taken without an idle bubble.
        if (bus.start) begin
          accept  = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (accept) begin
      a_q     <= bus.a;
      b_q     <= sub_in ? ~bus.b : bus.b;
      carry_q <= sub_in ? 1'b1 : bus.cin;
      idx_q   <= '0;
    end else if (state_q == RUN) begin
      sum_q[{idx_q, 2'b00} +: 4] <= snib;
      carry_q <= c[3];
      idx_q   <= idx_q + 1'b1;
      if (idx_q == LAST) begin
        cout_q <= c[3];
        ovf_q  <= c[2] ^ c[3];
      end
    end
  end

  assign bus.busy  = (state_q == RUN);
  assign bus.ready = (state_q != RUN);
  assign bus.done  = (state_q == DONE);
  assign bus.sum   = sum_q;
  assign bus.cout  = cout_q;
  assign bus.ovf   = ovf_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_cla_nibble_seq_adder.sv
// Self-checking bench for cla_nibble_seq_adder (WIDTH=16): directed plan vectors,
// randomized operations against an arithmetic reference, and protocol corner cases.
module tb_cla_nibble_seq_adder;
  localparam int W   = 16;
  localparam int NIB = W / 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] dbg_state;
  int         checks = 0;
  int         errors = 0;
  logic [W+1:0] exp_q[$];

  cla_nibble_seq_adder_if #(.WIDTH(W)) bus();

  cla_nibble_seq_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  // Reference: {ovf, cout, sum} from plain wide arithmetic.
  function automatic logic [W+1:0] ref_op(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic ci, input logic s);
    logic [W:0]   full;
    logic [W-1:0] yy;
    logic         c;
    logic         ov;
    yy   = s ? ~y : y;
    c    = s ? 1'b1 : ci;
    full = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, c};
    ov   = (x[W-1] == yy[W-1]) && (full[W-1] != x[W-1]);
    return {ov, full[W], full[W-1:0]};
  endfunction

  task automatic drive_sub(input logic s);
`ifdef CLA_SEQ_SUB_EN
    bus.sub = s;
`endif
  endtask

  // Waits for ready, presents the request for one edge, returns just after edge 0.
  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci,
                       input logic s);
    int n = 0;
    while (!bus.ready && n < 32) begin
      @(negedge clk);
      n++;
    end
    if (!bus.ready) begin
      checks++; errors++;
      $display("FAIL issue_ready_timeout got ready=%b want 1", bus.ready);
    end
    bus.start = 1'b1; bus.a = x; bus.b = y; bus.cin = ci; drive_sub(s);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Counts edges after edge 0 until done; scrambles inputs meanwhile.
  task automatic wait_done(output int lat, output bit to, output bit run_ok);
    lat = 0; to = 1'b1; run_ok = 1'b1;
    for (int i = 0; i < 32; i++) begin
      if (!bus.busy || bus.ready || bus.done) run_ok = 1'b0;
      bus.a = W'($urandom); bus.b = W'($urandom); bus.cin = 1'($urandom_range(0, 1));
      drive_sub(1'($urandom_range(0, 1)));
      @(negedge clk);
      lat++;
      if (bus.done) begin
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    if (bus.sum !== 16'h0) begin errors++; $display("FAIL rst_sum got %h want 0000", bus.sum); end
    checks++;
    if (bus.cout !== 1'b0) begin errors++; $display("FAIL rst_cout got %b want 0", bus.cout); end
    checks++;
    if (bus.ovf !== 1'b0) begin errors++; $display("FAIL rst_ovf got %b want 0", bus.ovf); end
    checks++;
    if (bus.done !== 1'b0) begin errors++; $display("FAIL rst_done got %b want 0", bus.done); end
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", bus.busy); end
    checks++;
    if (bus.ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b want 1", bus.ready); end
    checks++;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    if (bus.ready !== 1'b1 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL idle_after_rst got ready=%b busy=%b want 1/0", bus.ready, bus.busy);
    end
    checks++;
  endtask

  task automatic test_directed();
    logic [W-1:0] ta[4]  = '{16'hFFFF, 16'h1234, 16'h7FFF, 16'h0F0F};
    logic [W-1:0] tb_[4] = '{16'h0001, 16'h4321, 16'h0001, 16'h00F1};
    logic         tc[4]  = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [W-1:0] es[4]  = '{16'h0000, 16'h5556, 16'h8000, 16'h1000};
    logic         eco[4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    logic         eov[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    int lat; bit to, run_ok;
    logic [W-1:0] held;
    for (int i = 0; i < 4; i++) begin
      issue(ta[i], tb_[i], tc[i], 1'b0);
      wait_done(lat, to, run_ok);
      checks++;
      if (to || lat != NIB) begin errors++; $display("FAIL dir%0d_latency got %0d want %0d", i, lat, NIB); end
      checks++;
      if (!run_ok) begin errors++; $display("FAIL dir%0d_run_flags busy/ready wrong during RUN", i); end
      checks++;
      if (bus.sum !== es[i] || bus.cout !== eco[i] || bus.ovf !== eov[i]) begin
        errors++;
        $display("FAIL dir%0d_result got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                 i, bus.sum, bus.cout, bus.ovf, es[i], eco[i], eov[i]);
      end
      held = bus.sum;
      repeat (2) @(negedge clk);
      checks++;
      if (bus.done !== 1'b0 || bus.sum !== held) begin
        errors++; $display("FAIL dir%0d_hold got done=%b sum=%h want 0/%h", i, bus.done, bus.sum, held);
      end
    end
  endtask

  task automatic test_random();
    int lat; bit to, run_ok;
    logic [W-1:0] x, y;
    logic ci, s;
    logic [W+1:0] e;
    for (int i = 0; i < 40; i++) begin
      x = W'($urandom); y = W'($urandom); ci = 1'($urandom_range(0, 1));
`ifdef CLA_SEQ_SUB_EN
      s = 1'($urandom_range(0, 1));
`else
      s = 1'b0;
`endif
      exp_q.push_back(ref_op(x, y, ci, s));
      issue(x, y, ci, s);
      wait_done(lat, to, run_ok);
      e = exp_q.pop_front();
      checks++;
      if (to || bus.sum !== e[W-1:0] || bus.cout !== e[W] || bus.ovf !== e[W+1]) begin
        errors++;
        $display("FAIL rand%0d a=%h b=%h cin=%b sub=%b got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                 i, x, y, ci, s, bus.sum, bus.cout, bus.ovf, e[W-1:0], e[W], e[W+1]);
      end
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    int lat; bit to, run_ok;
    issue(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    wait_done(lat, to, run_ok);
    checks++;
    if (to || bus.sum !== 16'h8000 || bus.ovf !== 1'b1 || bus.cout !== 1'b0) begin
      errors++; $display("FAIL b2b_first got sum=%h cout=%b ovf=%b want 8000/0/1", bus.sum, bus.cout, bus.ovf);
    end
    bus.start = 1'b1; bus.a = 16'h0001; bus.b = 16'h0001; bus.cin = 1'b0; drive_sub(1'b0);
    @(negedge clk);
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_accept got busy=%b want 1", bus.busy); end
    wait_done(lat, to, run_ok);
    checks++;
    if (to || lat != NIB || bus.sum !== 16'h0002 || bus.cout !== 1'b0 || bus.ovf !== 1'b0) begin
      errors++; $display("FAIL b2b_second got lat=%0d sum=%h cout=%b ovf=%b want %0d/0002/0/0",
                         lat, bus.sum, bus.cout, bus.ovf, NIB);
    end
    @(negedge clk);
  endtask

  task automatic test_start_during_run();
    int n_done = 0;
    logic [W-1:0] s_at_done = '0;
    logic         c_at_done = 1'b1;
    issue(16'h1234, 16'h4321, 1'b1, 1'b0);
    @(negedge clk);
    bus.start = 1'b1; bus.a = 16'hAAAA; bus.b = 16'h5555;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (bus.done) begin
        n_done++;
        s_at_done = bus.sum;
        c_at_done = bus.cout;
      end
      @(negedge clk);
    end
    checks++;
    if (n_done != 1) begin errors++; $display("FAIL ignore_start_pulses got %0d want 1", n_done); end
    checks++;
    if (s_at_done !== 16'h5556 || c_at_done !== 1'b0) begin
      errors++; $display("FAIL ignore_start_result got sum=%h cout=%b want 5556/0", s_at_done, c_at_done);
    end
  endtask

  task automatic test_reset_mid_run();
    int n_done = 0;
    int lat; bit to, run_ok;
    issue(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (bus.sum !== 16'h0 || bus.busy !== 1'b0 || bus.ready !== 1'b1 || bus.done !== 1'b0) begin
      errors++; $display("FAIL midrst_outputs got sum=%h busy=%b ready=%b done=%b want 0000/0/1/0",
                         bus.sum, bus.busy, bus.ready, bus.done);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (bus.done) n_done++;
      @(negedge clk);
    end
    checks++;
    if (n_done != 0) begin errors++; $display("FAIL midrst_no_done got %0d want 0", n_done); end
    issue(16'h0F0F, 16'h00F1, 1'b0, 1'b0);
    wait_done(lat, to, run_ok);
    checks++;
    if (to || bus.sum !== 16'h1000 || bus.cout !== 1'b0) begin
      errors++; $display("FAIL midrst_next got sum=%h cout=%b want 1000/0", bus.sum, bus.cout);
    end
    @(negedge clk);
  endtask

`ifdef CLA_SEQ_SUB_EN
  task automatic test_sub();
    int lat; bit to, run_ok;
    issue(16'h0005, 16'h0007, 1'b0, 1'b1);
    wait_done(lat, to, run_ok);
    checks++;
    if (to || bus.sum !== 16'hFFFE || bus.cout !== 1'b0 || bus.ovf !== 1'b0) begin
      errors++; $display("FAIL sub_borrow got sum=%h cout=%b ovf=%b want FFFE/0/0", bus.sum, bus.cout, bus.ovf);
    end
    issue(16'h8000, 16'h0001, 1'b0, 1'b1);
    wait_done(lat, to, run_ok);
    checks++;
    if (to || bus.sum !== 16'h7FFF || bus.cout !== 1'b1 || bus.ovf !== 1'b1) begin
      errors++; $display("FAIL sub_ovf got sum=%h cout=%b ovf=%b want 7FFF/1/1", bus.sum, bus.cout, bus.ovf);
    end
    @(negedge clk);
  endtask
`endif

  initial begin
    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0; drive_sub(1'b0);
    repeat (2) @(negedge clk);
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_start_during_run();
    test_reset_mid_run();
`ifdef CLA_SEQ_SUB_EN
    test_sub();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cla_nibble_seq_adder.md
Name: cla_nibble_seq_adder

Overview:
- Multi-cycle wide adder controller. Adds two WIDTH-bit operands with one shared 4-bit carry-lookahead slice, one nibble per clock, LSB nibble first.
- Latches operands on start, sequences the slice across WIDTH/4 nibbles, registers the carry between nibbles, and reports the result with a one-cycle done pulse.
- Sits between a requester (ALU/accumulator control) and the 4-bit CLA adder datapath.

Parameters:
- WIDTH, 16, operand width in bits. Must be a multiple of 4 and at least 8.
- NIB, WIDTH/4, derived nibble count. Not overridable.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- start  in  1  request. Sampled only when ready=1.
- a  in  WIDTH  operand A. Sampled with start.
- b  in  WIDTH  operand B. Sampled with start.
- cin  in  1  carry-in. Sampled with start.
- ready  out  1  high in IDLE and DONE; a new request can be accepted.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse; result valid.
- sum  out  WIDTH  result. Held until the next accepted start.
- cout  out  1  carry out of bit WIDTH-1.
- ovf  out  1  signed overflow (carry into MSB XOR cout).

Behaviour:
- Reset (async, rst=1): state=IDLE, nibble index=0, carry reg=0, operand regs=0. Outputs: sum=0, cout=0, ovf=0, done=0, busy=0, ready=1. Reset applied mid-RUN aborts the operation; no done is produced.
- States: IDLE, RUN, DONE. done = (state==DONE). busy = (state==RUN). ready = !busy.
- IDLE, start=1: at edge 0, latch a, b and cin into the carry reg; set idx=0; go to RUN. If start=0, stay in IDLE.
- RUN, edge k (k=1..NIB): process nibble idx=k-1.
  - Per bit: G=a&b, P=a^b.
  - Carries: c0=G0|P0c, c1=G1|P1G0|P1P0c, c2..c3 by the same lookahead expansion. c is the carry reg.
  - Sum nibble = P ^ {c2,c1,c0,c}. Write it into sum[4idx+3:4idx]. Carry reg <= c3. idx++.
- When idx==NIB-1 is processed (edge NIB): cout<=c3, ovf<=c2^c3, go to DONE. Latency is NIB clocks from the start edge to done high.
- DONE: done=1 for exactly one cycle.
  - start=1: accept the new request exactly as from IDLE (back-to-back, no bubble) and go to RUN.
  - start=0: go to IDLE.
- start during RUN is ignored; it is neither queued nor affects the result. Input changes during RUN have no effect because operands are latched.
- sum is updated nibble by nibble during RUN, so intermediate values are visible. It is only guaranteed when done=1 and afterwards until the next accepted start.
- cout and ovf are updated only at the final nibble.
- Wrap-around: result is modulo 2^WIDTH; the carry beyond it is reported on cout only.

Optional Feature:
- Macro: CLA_SEQ_SUB_EN.
- Defined: adds input port sub (1 bit), sampled with start.
  - sub=1: operand B is latched inverted and the carry reg is loaded with 1 (cin ignored), giving a-b.
  - cout=1 means no borrow. ovf is signed subtraction overflow.
  - sub=0: normal add.
- Not defined: no sub port; always a+b+cin.

Test Plan (WIDTH=16):
- Reset release, a=0xFFFF, b=0x0001, cin=0, start 1 cycle -> busy for 4 cycles, done at 4th edge after start, sum=0x0000, cout=1, ovf=0.
- a=0x1234, b=0x4321, cin=1 -> sum=0x5556, cout=0, ovf=0; ready=0 during RUN.
- a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1. Then start held in DONE with a=0x0001, b=0x0001 -> accepted immediately, next done gives sum=0x0002.
- start pulsed in 2nd RUN cycle with a=0xAAAA -> ignored; first result unchanged, exactly one done pulse.
- rst asserted in 3rd RUN cycle -> immediately sum=0, busy=0, ready=1, no done. Next start with 0x0F0F+0x00F1 -> sum=0x1000, cout=0.
- CLA_SEQ_SUB_EN defined: sub=1, a=0x0005, b=0x0007 -> sum=0xFFFE, cout=0. Then sub=1, a=0x8000, b=0x0001 -> sum=0x7FFF, ovf=1.
